number_draw_sequencer: RTL and testbench
========================================

// Module: number_draw_sequencer
// PURPOSE
// Sequences glyph drawing for one tile: takes a draw request (digit, tile origin), walks that digit's
// stroke list in an external stroke ROM, and expands each horizontal/vertical stroke into one pixel
// per accepted cycle for the VGA plot path. It replaces hard-wired per-digit drawers with one shared
// engine. The game-state datapath issues requests; the VGA adapter consumes the pixels.
// PARAMETERS
// DIGIT_W      4   digit code width (up to 16 glyphs)
// STROKE_W     3   stroke index width (max 2**STROKE_W strokes per glyph)
// PORTS
// clk          in   1          system clock, all logic on rising edge
// reset        in   1          synchronous, active-high
// start        in   1          draw request; sampled only in IDLE
// digit        in   DIGIT_W    glyph code, captured with start
// x_origin     in   8          tile x origin, captured with start
// y_origin     in   7          tile y origin, captured with start
// busy         out  1          high in every state except IDLE
// rom_addr     out  DIGIT_W+STROKE_W  {digit, stroke_idx}
// rom_data     in   17         [16]last [15]dir(0=horiz,1=vert) [14:10]sx [9:5]sy [4:0]len
// plot         out  1          pixel valid
// plot_ready   in   1          pixel accepted when plot & plot_ready
// x_out        out  8          pixel x
// y_out        out  7          pixel y
// done         out  1          one-cycle pulse when glyph complete
// BEHAVIOUR
// - Reset: state IDLE; busy=0, plot=0, done=0, x_out=0, y_out=0, rom_addr=0, stroke_idx=0, pix_cnt=0.
// - Reset mid-draw aborts immediately; no done pulse; no further plot.
// - States: IDLE -> FETCH -> LOAD -> DRAW -> (FETCH | DONE) -> IDLE.
// - IDLE: start=1 captures digit/x_origin/y_origin, stroke_idx<=0, go FETCH. start while busy ignored.
// - FETCH: rom_addr={digit,stroke_idx}; ROM is registered, data valid next cycle. Go LOAD.
// - LOAD: register sx,sy,len,dir,last; pix_cnt<=0. len==0: stroke empty -> skip DRAW,
//   apply end-of-stroke rule directly. Else go DRAW.
// - DRAW: plot=1; x_out=x_origin+sx+(dir?0:pix_cnt), y_out=y_origin+sy+(dir?pix_cnt:0).
//   Sums truncate: x mod 256, y mod 128 (wrap, no saturation).
//   plot_ready=0: hold plot, x_out, y_out stable. Accept: pix_cnt++; at pix_cnt==len-1 stroke ends.
// - End of stroke: if last=1 or stroke_idx==2**STROKE_W-1 go DONE, else stroke_idx++ and FETCH.
// - DONE: done=1 for exactly one cycle, busy=1; next cycle IDLE (busy=0). start in DONE ignored.
// - Latency: start at cycle T -> FETCH T+1, LOAD T+2, first plot T+3. Inter-stroke bubble: 2 cycles
//   (FETCH, LOAD) with plot=0. Zero-stall glyph of n strokes, L total pixels: done at T+3+L+2(n-1).
// - plot is 0 in all states except DRAW; x_out/y_out hold last value outside DRAW.
// - Stroke length 1..31 pixels; len field counts pixels drawn (len=7 -> offsets 0..6).
// TESTING
// 1 Reset: assert reset 2 cycles mid-DRAW -> next cycle plot=0,busy=0,done=0, state IDLE, no done.
// 2 Digit 7 at (40,30), ROM {h sx=11 sy=7 len=7},{last v sx=17 sy=9 len=13}, plot_ready=1 ->
//   pixels (51..57,37) then (57,39..51); first plot T+3, 20 plots total, done at T+25.
// 3 Backpressure: same request, plot_ready toggles 1,0,0,1... -> coordinates held while stalled,
//   no duplicate or dropped pixel, sequence identical to scenario 2.
// 4 Wrap: origin (250,125), stroke h sx=3 sy=2 len=4 last -> x_out 253,254,255,0; y_out 127 each.
// 5 Boundaries: stroke len=0 mid-list -> skipped, no plot; 8 strokes none last -> stops after
//   stroke_idx 7, rom_addr never wraps to {digit,0}.
// 6 start held high through busy and DONE -> exactly one draw; new draw only after IDLE resampled.

Source files
------------

// File: rtl/number_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : number_draw_sequencer
// Description : Shared glyph-drawing engine. Captures a draw request (digit
//               code plus tile origin), walks the digit's stroke list in an
//               external registered stroke ROM and expands every horizontal
//               or vertical stroke into one pixel per accepted cycle on a
//               plot/plot_ready handshake towards the VGA plot path.
// Revision    : 1.0 - initial release
// ============================================================================
module number_draw_sequencer #(
  parameter int DIGIT_W  = 4,
  parameter int STROKE_W = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DIGIT_W-1:0]          digit,
  input  logic [7:0]                  x_origin,
  input  logic [6:0]                  y_origin,
  output logic                        busy,
  output logic [DIGIT_W+STROKE_W-1:0] rom_addr,
  input  logic [16:0]                 rom_data,
  output logic                        plot,
  input  logic                        plot_ready,
  output logic [7:0]                  x_out,
  output logic [6:0]                  y_out,
  output logic                        done
);

  localparam logic [STROKE_W-1:0] STROKE_ONE  = STROKE_W'(1);
  localparam logic [STROKE_W-1:0] STROKE_LAST = '1;
  localparam logic [4:0]          LEN_ZERO    = 5'd0;
  localparam logic [4:0]          PIX_ONE     = 5'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q,      state_d;
  logic [DIGIT_W-1:0]    digit_q,      digit_d;
  logic [7:0]            x_org_q,      x_org_d;
  logic [6:0]            y_org_q,      y_org_d;
  logic [STROKE_W-1:0]   stroke_idx_q, stroke_idx_d;
  logic [4:0]            sx_q,         sx_d;
  logic [4:0]            sy_q,         sy_d;
  logic [4:0]            len_q,        len_d;
  logic                  dir_q,        dir_d;
  logic                  last_q,       last_d;
  logic [4:0]            pix_cnt_q,    pix_cnt_d;
  logic [7:0]            x_last_q,     x_last_d;
  logic [6:0]            y_last_q,     y_last_d;

  // ROM field views of the word returned for the stroke fetched last cycle
  logic       rom_last;
  logic       rom_dir;
  logic [4:0] rom_sx;
  logic [4:0] rom_sy;
  logic [4:0] rom_len;

  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic       stroke_is_final;

  assign rom_last = rom_data[16];
  assign rom_dir  = rom_data[15];
  assign rom_sx   = rom_data[14:10];
  assign rom_sy   = rom_data[9:5];
  assign rom_len  = rom_data[4:0];

  // The address is a pure function of the captured digit and stroke index, so
  // it reads zero out of reset and is stable while the ROM samples it in FETCH.
  assign rom_addr = {digit_q, stroke_idx_q};

  // Current pixel coordinate; sums wrap naturally at 8 bits (x) and 7 bits (y).
  always_comb begin
    pix_x = x_org_q + {3'b000, sx_q} + (dir_q ? 8'd0 : {3'b000, pix_cnt_q});
    pix_y = y_org_q + {2'b00, sy_q} + (dir_q ? {2'b00, pix_cnt_q} : 7'd0);
  end

  // In LOAD the last flag comes straight from the ROM (empty-stroke skip);
  // in DRAW it comes from the registered copy. The index check stops the walk
  // after the final ROM slot of the glyph instead of wrapping to stroke 0.
  always_comb begin
    stroke_is_final = ((state_q == S_LOAD) ? rom_last : last_q) ||
                      (stroke_idx_q == STROKE_LAST);
  end

  // Outside DRAW the coordinates hold the last pixel that was presented.
  always_comb begin
    x_out = (state_q == S_DRAW) ? pix_x : x_last_q;
    y_out = (state_q == S_DRAW) ? pix_y : y_last_q;
  end

  // Next-state and output decode for the stroke-walking sequencer
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    x_org_d      = x_org_q;
    y_org_d      = y_org_q;
    stroke_idx_d = stroke_idx_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    len_d        = len_q;
    dir_d        = dir_q;
    last_d       = last_q;
    pix_cnt_d    = pix_cnt_q;
    x_last_d     = x_last_q;
    y_last_d     = y_last_q;
    busy         = 1'b1;
    plot         = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          digit_d      = digit;
          x_org_d      = x_origin;
          y_org_d      = y_origin;
          stroke_idx_d = '0;
          state_d      = S_FETCH;
        end
      end

      S_FETCH: begin
        // rom_addr is presented this cycle; the registered ROM answers in LOAD
        state_d = S_LOAD;
      end

      S_LOAD: begin
        sx_d      = rom_sx;
        sy_d      = rom_sy;
        len_d     = rom_len;
        dir_d     = rom_dir;
        last_d    = rom_last;
        pix_cnt_d = '0;
        if (rom_len == LEN_ZERO) begin
          // Empty stroke: skip DRAW and move straight to the end-of-stroke rule
          if (stroke_is_final) begin
            state_d = S_DONE;
          end else begin
            stroke_idx_d = stroke_idx_q + STROKE_ONE;
            state_d      = S_FETCH;
          end
        end else begin
          state_d = S_DRAW;
        end
      end

      S_DRAW: begin
        plot     = 1'b1;
        x_last_d = pix_x;
        y_last_d = pix_y;
        if (plot_ready) begin
          if (pix_cnt_q == (len_q - PIX_ONE)) begin
            if (stroke_is_final) begin
              state_d = S_DONE;
            end else begin
              stroke_idx_d = stroke_idx_q + STROKE_ONE;
              state_d      = S_FETCH;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_ONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset aborts any draw
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      digit_q      <= '0;
      x_org_q      <= '0;
      y_org_q      <= '0;
      stroke_idx_q <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      len_q        <= '0;
      dir_q        <= 1'b0;
      last_q       <= 1'b0;
      pix_cnt_q    <= '0;
      x_last_q     <= '0;
      y_last_q     <= '0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      x_org_q      <= x_org_d;
      y_org_q      <= y_org_d;
      stroke_idx_q <= stroke_idx_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      len_q        <= len_d;
      dir_q        <= dir_d;
      last_q       <= last_d;
      pix_cnt_q    <= pix_cnt_d;
      x_last_q     <= x_last_d;
      y_last_q     <= y_last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_number_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_number_draw_sequencer
// Description : Directed self-checking bench for number_draw_sequencer with a
//               registered stroke ROM model and hand-computed pixel lists.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_number_draw_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  digit;
  logic [7:0]  x_origin;
  logic [6:0]  y_origin;
  logic        busy;
  logic [6:0]  rom_addr;
  logic [16:0] rom_data;
  logic        plot;
  logic        plot_ready;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  logic [16:0] rom [0:127];
  logic [14:0] exp_px [$];

  number_draw_sequencer #(.DIGIT_W(4), .STROKE_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .digit      (digit),
    .x_origin   (x_origin),
    .y_origin   (y_origin),
    .busy       (busy),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .plot       (plot),
    .plot_ready (plot_ready),
    .x_out      (x_out),
    .y_out      (y_out),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Registered stroke ROM: data for an address appears one cycle later
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [16:0] mk(input bit l, input bit dr, input int sx, input int sy, input int len);
    return {l, dr, 5'(sx), 5'(sy), 5'(len)};
  endfunction

  task automatic px(input int x, input int y);
    exp_px.push_back({8'(x), 7'(y)});
  endtask

  // Issue one request and follow it to done, checking every accepted pixel,
  // coordinate hold during stalls, first-plot latency and done timing.
  task automatic do_draw(input string tag, input logic [3:0] d, input logic [7:0] xo,
                         input logic [6:0] yo, input bit stall, input bit hold_start,
                         input int exp_done);
    int   idx;
    int   first;
    bit   seen_done;
    bit   pend;
    bit   wrapped;
    int   lo_max;
    logic [7:0] hx;
    logic [6:0] hy;
    idx = 0; first = -1; seen_done = 1'b0; pend = 1'b0; wrapped = 1'b0; lo_max = 0;
    hx = '0; hy = '0;
    @(negedge clk);
    start = 1'b1; digit = d; x_origin = xo; y_origin = yo; plot_ready = 1'b1;
    for (int cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      plot_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (busy) begin
        if (int'(rom_addr[2:0]) < lo_max) wrapped = 1'b1;
        if (int'(rom_addr[2:0]) > lo_max) lo_max = int'(rom_addr[2:0]);
      end
      if (pend) begin
        chk({tag, "_hold_plot"}, plot, 1);
        chk({tag, "_hold_x"}, x_out, hx);
        chk({tag, "_hold_y"}, y_out, hy);
      end
      pend = 1'b0;
      if (plot) begin
        if (first < 0) first = cyc;
        if (plot_ready) begin
          if (idx < exp_px.size()) begin
            chk({tag, "_px_x"}, x_out, exp_px[idx][14:7]);
            chk({tag, "_px_y"}, y_out, exp_px[idx][6:0]);
          end else begin
            chk({tag, "_extra_px"}, idx, exp_px.size() - 1);
          end
          idx++;
        end else begin
          pend = 1'b1;
          hx = x_out;
          hy = y_out;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        chk({tag, "_busy_in_done"}, busy, 1);
        chk({tag, "_px_count"}, idx, exp_px.size());
        chk({tag, "_first_plot"}, first, 3);
        if (exp_done > 0) chk({tag, "_done_cycle"}, cyc, exp_done);
      end
    end
    chk({tag, "_done_seen"}, seen_done, 1);
    chk({tag, "_rom_no_wrap"}, wrapped, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int  plots;
    bit  got;
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[56] = mk(0, 0, 11, 7, 7);      // digit 7 stroke 0
    rom[57] = mk(1, 1, 17, 9, 13);     // digit 7 stroke 1
    rom[16] = mk(1, 0, 3, 2, 4);       // digit 2 single stroke
    rom[40] = mk(0, 0, 0, 0, 2);       // digit 5: h, empty, last v
    rom[41] = mk(0, 0, 0, 0, 0);
    rom[42] = mk(1, 1, 1, 1, 2);
    for (int i = 0; i < 8; i++) rom[72 + i] = mk(0, 0, i, 0, 1);  // digit 9: 8 strokes, none last

    reset = 1'b1; start = 1'b0; digit = '0; x_origin = '0; y_origin = '0; plot_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_plot", plot, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_addr", rom_addr, 0);
    reset = 1'b0;

    // Reset in the middle of a stroke aborts the draw
    @(negedge clk);
    start = 1'b1; digit = 4'd7; x_origin = 8'd40; y_origin = 7'd30;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_plot_before_rst", plot, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_plot", plot, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_x", x_out, 0);
    chk("post_rst_y", y_out, 0);
    got = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || plot || busy) got = 1'b1;
    end
    chk("post_rst_quiet", got, 0);

    // Digit 7, no stall
    exp_px.delete();
    for (int x = 51; x <= 57; x++) px(x, 37);
    for (int y = 39; y <= 51; y++) px(57, y);
    do_draw("d7", 4'd7, 8'd40, 7'd30, 1'b0, 1'b0, 25);

    // Same glyph under backpressure
    do_draw("d7bp", 4'd7, 8'd40, 7'd30, 1'b1, 1'b0, 0);

    // Coordinate wrap
    exp_px.delete();
    px(253, 127); px(254, 127); px(255, 127); px(0, 127);
    do_draw("wrap", 4'd2, 8'd250, 7'd125, 1'b0, 1'b0, 7);

    // Empty stroke in the middle of the list
    exp_px.delete();
    px(10, 10); px(11, 10); px(11, 11); px(11, 12);
    do_draw("len0", 4'd5, 8'd10, 7'd10, 1'b0, 1'b0, 11);

    // Eight strokes without a last flag
    exp_px.delete();
    for (int i = 0; i < 8; i++) px(i, 0);
    do_draw("full8", 4'd9, 8'd0, 7'd0, 1'b0, 1'b0, 25);

    // start held through busy and DONE: one draw, then a new one after IDLE
    exp_px.delete();
    for (int x = 51; x <= 57; x++) px(x, 37);
    for (int y = 39; y <= 51; y++) px(57, y);
    do_draw("hold", 4'd7, 8'd40, 7'd30, 1'b0, 1'b1, 25);
    @(negedge clk);
    chk("hold_restart_busy", busy, 1);
    start = 1'b0;
    got = 1'b0; plots = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (plot) plots++;
      if (done) got = 1'b1;
    end
    chk("hold_restart_done", got, 1);
    chk("hold_restart_plots", plots, 20);
    @(negedge clk);
    chk("hold_final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
